// File: rtl/df_process_scheduler.sv
// df_process_scheduler
// Dataflow start/done sequencer for the systolic MVM chain. A single top-level
// ap_ctrl_chain handshake is fanned out to NPROC process handshakes. Starts are
// latched per process until every process has taken the invocation, and dones
// are latched until all processes have finished the oldest invocation. At most
// MAX_INFLIGHT invocations may be outstanding at any time.
//
// Ports:
//   clock, reset     single clock, asynchronous active-high reset
//   ap_start         top start request, held until ap_ready
//   ap_ready         top invocation accepted this cycle (combinational)
//   ap_done          oldest invocation finished by all processes (combinational)
//   ap_continue      top consumer acknowledges ap_done
//   ap_idle          nothing in flight and no partially started invocation
//   proc_start       per-process start request
//   proc_ready       per-process start consumed
//   proc_done        per-process done, held until proc_continue
//   proc_continue    per-process continue pulse, all processes together
//   inflight         accepted-but-not-completed invocation count
//   iter_count       completed invocations, wraps at 2^32
//   stall            sticky watchdog flag
//   proto_err        sticky protocol-violation flag
module df_process_scheduler #(
    parameter int unsigned NPROC        = 3,
    parameter int unsigned MAX_INFLIGHT = 2,
    parameter int unsigned CW           = 4,
    parameter int unsigned WDOG_CYCLES  = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    output logic             ap_ready,
    output logic             ap_done,
    input  logic             ap_continue,
    output logic             ap_idle,
    output logic [NPROC-1:0] proc_start,
    input  logic [NPROC-1:0] proc_ready,
    input  logic [NPROC-1:0] proc_done,
    output logic [NPROC-1:0] proc_continue,
    output logic [CW-1:0]    inflight,
    output logic [31:0]      iter_count,
    output logic             stall,
    output logic             proto_err
);

    // Watchdog counter only needs to reach WDOG_CYCLES-1, where it saturates.
    localparam int unsigned SCW       = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [CW-1:0]  MAX_C  = CW'(MAX_INFLIGHT);
    localparam logic [SCW-1:0] WDOG_LAST = SCW'((WDOG_CYCLES > 0) ? WDOG_CYCLES - 1 : 0);

    logic [NPROC-1:0] rdy_lat;
    logic [NPROC-1:0] done_lat;
    logic [NPROC-1:0] done_prev;
    logic             start_prev;
    logic [SCW-1:0]   stall_cnt;

    logic             can_start;
    logic [NPROC-1:0] start_c;
    logic [NPROC-1:0] rdy_hit;
    logic             all_rdy;
    logic             accept;
    logic             all_done;
    logic             complete;
    logic [NPROC-1:0] done_rise;
    logic             event_hit;
    logic             active;

    // Handshake decode shared by outputs and state updates.
    always_comb begin
        can_start = ap_start && (inflight < MAX_C);
        start_c   = {NPROC{can_start}} & ~rdy_lat;
        rdy_hit   = start_c & proc_ready;
        all_rdy   = &(rdy_lat | rdy_hit);
        accept    = can_start && all_rdy;
        all_done  = (inflight != '0) && (&(done_lat | proc_done));
        complete  = all_done && ap_continue;
        done_rise = proc_done & ~done_prev;
        event_hit = (|rdy_hit) || (|done_rise) || accept || complete;
        active    = (inflight != '0) || (rdy_lat != '0);
    end

    // Handshake outputs are held quiet while reset is asserted.
    assign proc_start    = reset ? '0 : start_c;
    assign proc_continue = reset ? '0 : {NPROC{complete}};
    assign ap_ready      = !reset && accept;
    assign ap_done       = !reset && all_done;
    assign ap_idle       = reset || ((inflight == '0) && (rdy_lat == '0));

    // Per-process start and done latches.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdy_lat   <= '0;
            done_lat  <= '0;
            done_prev <= '0;
        end else begin
            done_prev <= proc_done;
            if (accept) begin
                rdy_lat <= '0;
            end else begin
                rdy_lat <= rdy_lat | rdy_hit;
            end
            // Dones seen with nothing in flight are protocol errors, not latched.
            if (complete) begin
                done_lat <= '0;
            end else if (inflight != '0) begin
                done_lat <= done_lat | proc_done;
            end
        end
    end

    // Outstanding-invocation and completion counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight   <= '0;
            iter_count <= '0;
        end else begin
            if (accept && !complete) begin
                inflight <= inflight + CW'(1);
            end else if (complete && !accept) begin
                inflight <= inflight - CW'(1);
            end
            if (complete) begin
                iter_count <= iter_count + 32'd1;
            end
        end
    end

    // Watchdog: count busy cycles without progress, flag once the limit is hit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            stall     <= 1'b0;
        end else if (WDOG_CYCLES != 0) begin
            if (event_hit) begin
                stall_cnt <= '0;
            end else if (active) begin
                if (stall_cnt == WDOG_LAST) begin
                    stall <= 1'b1;
                end else begin
                    stall_cnt <= stall_cnt + SCW'(1);
                end
            end
        end
    end

    // Sticky protocol checker: stray dones and start withdrawn mid-handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_prev <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            start_prev <= ap_start;
            if (((|proc_done) && (inflight == '0)) ||
                (start_prev && !ap_start && (rdy_lat != '0))) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/df_process_scheduler.md
Name: df_process_scheduler

Overview:
- Top-level dataflow start/done sequencer for the systolic MVM chain (producer3 → layer1 → consumer).
- Fans one top-level ap_ctrl_chain handshake out to NPROC process handshakes, with per-process start/ready latching and done/continue synchronisation.
- Limits outstanding invocations to MAX_INFLIGHT.
- Counts completed iterations and flags stalls and protocol violations for the dataflow monitors and deadlock reporting.

Parameters:
- NPROC, 3: number of dataflow processes sequenced.
- MAX_INFLIGHT, 2: maximum invocations accepted but not yet completed (≥1).
- CW, 4: width of the inflight counter; must hold MAX_INFLIGHT.
- WDOG_CYCLES, 1024: idle-activity cycles before the stall flag is set; 0 disables the watchdog.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- ap_start  in  1  top start request; held until ap_ready.
- ap_ready  out  1  top invocation accepted this cycle.
- ap_done  out  1  all processes finished oldest invocation; held until ap_continue.
- ap_continue  in  1  top consumer acknowledges ap_done.
- ap_idle  out  1  nothing in flight, no partial start.
- proc_start  out  NPROC  per-process start.
- proc_ready  in  NPROC  per-process ready (start consumed).
- proc_done  in  NPROC  per-process done, held until proc_continue.
- proc_continue  out  NPROC  per-process continue.
- inflight  out  CW  accepted-but-not-completed invocation count.
- iter_count  out  32  completed invocations, wraps at 2^32.
- stall  out  1  sticky watchdog flag.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async, active-high): inflight=0, iter_count=0, rdy_lat=0, done_lat=0, stall_cnt=0, stall=0, proto_err=0.
- While reset is high, proc_start, proc_continue, ap_ready and ap_done are forced to 0 and ap_idle is forced to 1.
- can_start = ap_start & (inflight < MAX_INFLIGHT).
- Start, per process: proc_start[i] = can_start & ~rdy_lat[i]. rdy_lat[i] is set on proc_start[i] & proc_ready[i].
- Start complete: all_rdy = &(rdy_lat | (proc_start & proc_ready)).
- ap_ready = can_start & all_rdy, combinational, same cycle as the last ready.
- On ap_ready, all rdy_lat clear next edge.
- Processes may become ready in different cycles; an already-ready process sees no further proc_start for that invocation.
- Done: done_lat[i] is set on proc_done[i]. all_done = (inflight != 0) & &(done_lat | proc_done).
- ap_done = all_done, held while ap_continue is low.
- proc_continue[i] = all_done & ap_continue, one-cycle pulse to every process simultaneously.
- On all_done & ap_continue, next edge: done_lat clears and iter_count increments.
- inflight update: +1 on ap_ready alone, −1 on completion alone. Simultaneous ap_ready and completion leave inflight unchanged. inflight never exceeds MAX_INFLIGHT and never goes negative.
- At inflight == MAX_INFLIGHT, proc_start and ap_ready stay 0 until a completion occurs. A completion frees the slot in the following cycle, not combinationally.
- ap_idle = (inflight == 0) & (rdy_lat == 0).
- Watchdog:
  - An event is any of: proc_ready bit high with its proc_start, a new proc_done rise, ap_ready, or completion.
  - stall_cnt increments each cycle with inflight != 0 or rdy_lat != 0 and no event; it clears on any event.
  - stall sets when stall_cnt reaches WDOG_CYCLES−1 and stays set until reset. stall_cnt saturates.
- Protocol errors:
  - proto_err is set, sticky, by proc_done[i] while inflight == 0, or by ap_start falling while rdy_lat != 0 (start withdrawn mid-handshake).
  - On withdrawal, rdy_lat is kept and the invocation resumes when ap_start returns.
- iter_count wraps from 0xFFFFFFFF to 0 without error.

Test Plan:
- Single invocation, NPROC=3: ap_start=1, readies on cycles 2,3,5 → ap_ready high only in cycle 5, proc_start[0] low from cycle 3, inflight=1.
  - Then all dones on cycles 20,22,23 → ap_done=1 at cycle 23.
  - ap_continue=1 at 25 → proc_continue=3'b111 pulse, iter_count=1, inflight=0, ap_idle=1.
- Back-pressure, MAX_INFLIGHT=2: three back-to-back starts with immediate readies and no dones → two ap_ready pulses, third held (proc_start=0, inflight=2). First completion → third accepted the next cycle, inflight stays 2.
- Simultaneous accept and complete with inflight=1: ap_ready and completion in the same cycle → inflight stays 1, iter_count +1.
- Watchdog, WDOG_CYCLES=16: start accepted, then no dones for 16 cycles → stall=1 at cycle 16 and stays 1 after later dones. With WDOG_CYCLES=0 → stall never sets.
- Protocol error: proc_done[1]=1 with inflight=0 → proto_err=1, ap_done stays 0.
- Reset mid-operation: inflight=2, partial rdy_lat, reset pulsed asynchronously between clock edges → all outputs at reset values immediately, ap_idle=1; a fresh start after release succeeds with iter_count=0.
